multi_mode_counter: RTL

- Parametrised N-bit sequence generator that succeeds the fixed up/down and ring counters.
- Supports binary up, binary down, ring rotate (left/right) and Johnson (twisted-ring) modes. Has synchronous load, synchronous one-hot init, count enable and a registered wrap pulse.
- Used as the general-purpose sequencer/timer in datapath control, replacing per-use counter variants.

---
 rtl/multi_mode_counter.sv | 104 ++++++++++
 1 files changed

// File: rtl/multi_mode_counter.sv
// Parametrised up/down/ring/Johnson sequence generator with init, load, enable and wrap pulse.
// Optional build define MULTI_MODE_COUNTER_SATURATE_EN clamps binary modes instead of wrapping.

module multi_mode_counter #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      STEP    = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             init,
  input  logic             ld,
  input  logic [WIDTH-1:0] d_in,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             zero
);

  typedef enum logic [1:0] {
    ModeUp      = 2'b00,
    ModeDown    = 2'b01,
    ModeRing    = 2'b10,
    ModeJohnson = 2'b11
  } mode_e;

  localparam logic [WIDTH:0] StepExt = {1'b0, WIDTH'(STEP)};

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   sum, diff;
  mode_e            mode_sel;

  // The extra top bit carries out of the add and borrows out of the subtract.
  assign sum      = {1'b0, count_q} + StepExt;
  assign diff     = {1'b0, count_q} - StepExt;
  assign mode_sel = mode_e'(mode);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (init) begin
      count_d = SEED;
    end else if (ld) begin
      count_d = d_in;
    end else if (en) begin
      unique case (mode_sel)
        ModeUp: begin
`ifdef MULTI_MODE_COUNTER_SATURATE_EN
          count_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
          wrap_d  = (count_d == '1) && (count_q != '1);
`else
          count_d = sum[WIDTH-1:0];
          wrap_d  = sum[WIDTH];
`endif
        end
        ModeDown: begin
`ifdef MULTI_MODE_COUNTER_SATURATE_EN
          count_d = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
          wrap_d  = (count_d == '0) && (count_q != '0);
`else
          count_d = diff[WIDTH-1:0];
          wrap_d  = diff[WIDTH];
`endif
        end
        ModeRing: begin
          // An all-zero ring can never rotate a bit back in, so reseed it.
          if (count_q == '0) begin
            count_d = SEED;
          end else if (!dir) begin
            count_d = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
            wrap_d  = count_q[WIDTH-1];
          end else begin
            count_d = {count_q[0], count_q[WIDTH-1:1]};
            wrap_d  = count_q[0];
          end
        end
        ModeJohnson: begin
          count_d = dir ? {~count_q[0], count_q[WIDTH-1:1]}
                        : {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
          wrap_d  = (count_d == '0);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= RST_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign zero  = (count_q == '0);

endmodule
